// File: rtl/cam_pkg.sv
// Shared definitions for the DVP camera emulator and its controller:
// FSM state encoding, pattern selectors and default 640x480 RGB565 geometry.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        HBLANK,
        VFP
    } cam_state_t;

    localparam logic PAT_LINE  = 1'b0;
    localparam logic PAT_FRAME = 1'b1;

    localparam int DEF_VSYNC_CLKS = 15;
    localparam int DEF_VBP_CLKS   = 20;
    localparam int DEF_H_ACTIVE   = 1280;
    localparam int DEF_H_BLANK    = 288;
    localparam int DEF_V_LINES    = 480;
    localparam int DEF_VFP_CLKS   = 10;
    localparam int DEF_CW         = 16;

endpackage

// File: rtl/cam_timing_gen_if.sv
// DVP-style sensor bus plus frame status; the timing generator is the master,
// the camera controller (or a bench) is the slave.
interface cam_timing_gen_if;

    logic        enable;
    logic        pattern_sel;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    modport master (
        input  enable, pattern_sel,
        output vsync, href, data, busy, frame_done, frame_cnt
    );

    modport slave (
        output enable, pattern_sel,
        input  vsync, href, data, busy, frame_done, frame_cnt
    );

endinterface

// File: rtl/cam_pattern_gen.sv
// Byte ramp source for the test pattern: a per-line and a per-frame index,
// both mod 256, stepping once per active byte.
module cam_pattern_gen
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_clr,
    input  logic       frame_clr,
    input  logic       advance,
    input  logic       sel,
    output logic [7:0] byte_val
);

    logic [7:0] line_idx;
    logic [7:0] frame_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_idx  <= '0;
            frame_idx <= '0;
        end else begin
            if (line_clr)
                line_idx <= '0;
            else if (advance)
                line_idx <= line_idx + 8'd1;

            if (frame_clr)
                frame_idx <= '0;
            else if (advance)
                frame_idx <= frame_idx + 8'd1;
        end
    end

    // Index of the byte about to be emitted; natural 8-bit wrap gives FF->00.
    assign byte_val = (sel == PAT_FRAME) ? frame_idx : line_idx;

endmodule

// File: rtl/cam_timing_gen.sv
// DVP sensor emulator: VSYNC/HREF/data frame generator with programmable
// geometry, selectable ramp pattern and completed-frame counter.
module cam_timing_gen
    import cam_pkg::*;
#(
    parameter int VSYNC_CLKS = DEF_VSYNC_CLKS,
    parameter int VBP_CLKS   = DEF_VBP_CLKS,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int V_LINES    = DEF_V_LINES,
    parameter int VFP_CLKS   = DEF_VFP_CLKS,
    parameter int CW         = DEF_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    cam_timing_gen_if.master bus
);

    localparam logic [CW-1:0] VS_LAST   = CW'(VSYNC_CLKS - 1);
    localparam logic [CW-1:0] VBP_LAST  = CW'(VBP_CLKS - 1);
    localparam logic [CW-1:0] HA_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(V_LINES - 1);
    localparam logic [CW-1:0] VFP_LAST  = CW'(VFP_CLKS - 1);

    cam_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] line, line_nxt;
    logic          pat_sel_q;
    logic          advance;
    logic          frame_start;
    logic          frame_done_nxt;
    logic [7:0]    pat_byte;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        line_nxt  = line;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.enable)
                    state_nxt = VSYNC;
            end
            VSYNC: if (cnt == VS_LAST) begin
                state_nxt = VBP;
                cnt_nxt   = '0;
            end
            VBP: if (cnt == VBP_LAST) begin
                state_nxt = ACTIVE;
                cnt_nxt   = '0;
                line_nxt  = '0;
            end
            ACTIVE: if (cnt == HA_LAST) begin
                cnt_nxt   = '0;
                state_nxt = (line == LINE_LAST) ? VFP : HBLANK;
            end
            HBLANK: if (cnt == HB_LAST) begin
                state_nxt = ACTIVE;
                cnt_nxt   = '0;
                line_nxt  = line + CW'(1);
            end
            VFP: if (cnt == VFP_LAST) begin
                cnt_nxt   = '0;
                state_nxt = bus.enable ? VSYNC : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    assign advance        = (state_nxt == ACTIVE);
    assign frame_start    = (state_nxt == VSYNC) && (state != VSYNC);
    assign frame_done_nxt = (state_nxt == VFP) && (cnt_nxt == VFP_LAST);

    cam_pattern_gen u_pattern (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_clr  (!advance),
        .frame_clr (frame_start),
        .advance   (advance),
        .sel       (pat_sel_q),
        .byte_val  (pat_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            line           <= '0;
            pat_sel_q      <= PAT_LINE;
            bus.vsync      <= 1'b0;
            bus.href       <= 1'b0;
            bus.data       <= 8'h00;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_cnt  <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            line           <= line_nxt;
            if (frame_start)
                pat_sel_q <= bus.pattern_sel;
            bus.vsync      <= (state_nxt == VSYNC);
            bus.href       <= advance;
            bus.data       <= advance ? pat_byte : 8'h00;
            bus.busy       <= (state_nxt != IDLE);
            bus.frame_done <= frame_done_nxt;
            if (frame_done_nxt)
                bus.frame_cnt <= bus.frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cam_timing_gen.sv
// Bench for cam_timing_gen: a small-geometry instance and a long-line instance
// share stimulus and are checked against a frame-position reference model.
module tb_cam_timing_gen;

    localparam int A_VS = 3, A_VBP = 2, A_HA = 4,   A_HB = 2, A_VL = 3, A_VFP = 2;
    localparam int B_VS = 3, B_VBP = 2, B_HA = 300, B_HB = 2, B_VL = 2, B_VFP = 2;

    int G_VS  [2] = '{A_VS,  B_VS};
    int G_VBP [2] = '{A_VBP, B_VBP};
    int G_HA  [2] = '{A_HA,  B_HA};
    int G_HB  [2] = '{A_HB,  B_HB};
    int G_VL  [2] = '{A_VL,  B_VL};
    int G_VFP [2] = '{A_VFP, B_VFP};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    cam_timing_gen_if bus_a ();
    cam_timing_gen_if bus_b ();

    assign bus_a.enable      = en;
    assign bus_a.pattern_sel = sel;
    assign bus_b.enable      = en;
    assign bus_b.pattern_sel = sel;

    cam_timing_gen #(
        .VSYNC_CLKS(A_VS), .VBP_CLKS(A_VBP), .H_ACTIVE(A_HA),
        .H_BLANK(A_HB), .V_LINES(A_VL), .VFP_CLKS(A_VFP), .CW(16)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    cam_timing_gen #(
        .VSYNC_CLKS(B_VS), .VBP_CLKS(B_VBP), .H_ACTIVE(B_HA),
        .H_BLANK(B_HB), .V_LINES(B_VL), .VFP_CLKS(B_VFP), .CW(16)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: running flag, position within the frame, latched pattern, frame count.
    bit m_run [2];
    int m_p   [2];
    bit m_sel [2];
    int m_cnt [2];
    bit prev_fd [2];

    typedef struct {
        bit          r, e, s;
        logic [27:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int flen(int k);
        return G_VS[k] + G_VBP[k] + G_VL[k] * G_HA[k] + (G_VL[k] - 1) * G_HB[k] + G_VFP[k];
    endfunction

    function automatic logic [27:0] pack(bit vs, bit hr, logic [7:0] d, bit bz, bit fd, logic [15:0] fc);
        return {vs, hr, d, bz, fd, fc};
    endfunction

    function automatic logic [27:0] dut_out(int k);
        if (k == 0)
            return {bus_a.vsync, bus_a.href, bus_a.data, bus_a.busy, bus_a.frame_done, bus_a.frame_cnt};
        return {bus_b.vsync, bus_b.href, bus_b.data, bus_b.busy, bus_b.frame_done, bus_b.frame_cnt};
    endfunction

    function automatic logic [27:0] model_out(int k);
        bit vs, hr, bz, fd;
        logic [7:0] d;
        int q, per, act_len, ln, col;
        vs = 0; hr = 0; bz = 0; fd = 0; d = 8'h00;
        if (m_run[k]) begin
            bz = 1;
            vs = (m_p[k] < G_VS[k]);
            fd = (m_p[k] == flen(k) - 1);
            q = m_p[k] - G_VS[k] - G_VBP[k];
            per = G_HA[k] + G_HB[k];
            act_len = G_VL[k] * G_HA[k] + (G_VL[k] - 1) * G_HB[k];
            if (q >= 0 && q < act_len) begin
                ln  = q / per;
                col = q % per;
                if (col < G_HA[k]) begin
                    hr = 1;
                    d = m_sel[k] ? 8'((ln * G_HA[k] + col) % 256) : 8'(col % 256);
                end
            end
        end
        return pack(vs, hr, d, bz, fd, 16'(m_cnt[k]));
    endfunction

    task automatic model_step(input bit r, input bit e, input bit s);
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m_run[k] = 0; m_p[k] = 0; m_cnt[k] = 0;
            end else if (!m_run[k]) begin
                if (e) begin m_run[k] = 1; m_p[k] = 0; m_sel[k] = s; end
            end else if (m_p[k] == flen(k) - 1) begin
                if (e) begin m_p[k] = 0; m_sel[k] = s; end
                else m_run[k] = 0;
            end else begin
                m_p[k]++;
            end
            if (r && m_run[k] && m_p[k] == flen(k) - 1)
                m_cnt[k] = (m_cnt[k] + 1) % 65536;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample on the falling edge.
    task automatic tick(input bit r, input bit e, input bit s);
        logic [27:0] o;
        rst_n = r; en = e; sel = s;
        @(posedge clk);
        model_step(r, e, s);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = dut_out(k);
            chk("vsync_href_excl", 28'(o[27] & o[26]), 28'h0);
            chk("data_zero_blank", 28'(o[26] ? 8'h00 : o[25:18]), 28'h0);
            chk("frame_done_width", 28'(prev_fd[k] & o[16]), 28'h0);
            prev_fd[k] = o[16];
        end
    endtask

    task automatic check_model();
        chk("model_a", dut_out(0), model_out(0));
        chk("model_b", dut_out(1), model_out(1));
    endtask

    initial begin
        logic [7:0] bytes_q[$];
        logic [27:0] o;
        int fd_seen, vs_rise;
        bit prev_vs;

        // Frame 1 of the small instance, line ramp, enable pulsed for one clock.
        tbl.push_back('{0, 0, 0, pack(0, 0, 8'h00, 0, 0, 16'd0)});
        tbl.push_back('{1, 1, 0, pack(1, 0, 8'h00, 1, 0, 16'd0)});
        for (int i = 0; i < 2; i++) tbl.push_back('{1, 0, 0, pack(1, 0, 8'h00, 1, 0, 16'd0)});
        for (int i = 0; i < 2; i++) tbl.push_back('{1, 0, 0, pack(0, 0, 8'h00, 1, 0, 16'd0)});
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 4; c++) tbl.push_back('{1, 0, 0, pack(0, 1, 8'(c), 1, 0, 16'd0)});
            if (l < 2)
                for (int i = 0; i < 2; i++) tbl.push_back('{1, 0, 0, pack(0, 0, 8'h00, 1, 0, 16'd0)});
        end
        tbl.push_back('{1, 0, 0, pack(0, 0, 8'h00, 1, 0, 16'd0)});
        tbl.push_back('{1, 0, 0, pack(0, 0, 8'h00, 1, 1, 16'd1)});
        for (int i = 0; i < 2; i++) tbl.push_back('{1, 0, 0, pack(0, 0, 8'h00, 0, 0, 16'd1)});

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].r, tbl[i].e, tbl[i].s);
            chk($sformatf("table_a[%0d]", i), dut_out(0), tbl[i].exp);
            chk("model_b", dut_out(1), model_out(1));
        end

        // Back-to-back frames with the frame ramp.
        bytes_q.delete();
        for (int i = 0; i < 50; i++) begin
            tick(1, 1, 1);
            check_model();
            o = dut_out(0);
            if (i <= 22 && o[26]) bytes_q.push_back(o[25:18]);
            if (i == 22) chk("b2b_frame_done_cnt", {11'h0, o[16], o[15:0]}, {11'h0, 1'b1, 16'd2});
            if (i == 23) chk("b2b_vsync_next", 28'(o[27]), 28'h1);
        end
        chk("b2b_byte_count", 28'(bytes_q.size()), 28'd12);
        for (int j = 0; j < 12 && j < bytes_q.size(); j++)
            chk($sformatf("b2b_byte[%0d]", j), 28'(bytes_q[j]), 28'(j));

        // Reset during line 1 of the active region, enable held.
        tick(0, 0, 0); check_model();
        tick(1, 1, 0); check_model();
        for (int i = 0; i < 12; i++) begin tick(1, 0, 0); check_model(); end
        chk("mid_href_line1", 28'(dut_out(0) >> 26 & 28'h1), 28'h1);
        tick(0, 1, 0);
        chk("mid_reset_zero", dut_out(0), 28'h0);
        tick(1, 1, 0);
        chk("restart_vsync", dut_out(0), pack(1, 0, 8'h00, 1, 0, 16'd0));
        for (int i = 0; i < 25; i++) begin tick(1, 0, 0); check_model(); end

        // Enable dropped during VBP: the frame still completes, then idle.
        fd_seen = 0; vs_rise = 0; prev_vs = 0;
        tick(0, 0, 0); check_model();
        for (int i = 0; i < 44; i++) begin
            tick(1, (i < 4), 0);
            check_model();
            o = dut_out(0);
            if (o[16]) fd_seen++;
            if (o[27] && !prev_vs) vs_rise++;
            prev_vs = o[27];
        end
        chk("drop_frame_done_count", 28'(fd_seen), 28'd1);
        chk("drop_vsync_rises", 28'(vs_rise), 28'd1);
        chk("drop_final_state", dut_out(0), pack(0, 0, 8'h00, 0, 0, 16'd1));

        // Long line on the second instance: the line ramp wraps at byte 256.
        bytes_q.delete();
        tick(0, 0, 0); check_model();
        for (int i = 0; i < 621; i++) begin
            tick(1, (i == 0), 0);
            check_model();
            o = dut_out(1);
            if (o[26]) bytes_q.push_back(o[25:18]);
        end
        chk("wrap_byte_count", 28'(bytes_q.size()), 28'd600);
        if (bytes_q.size() == 600) begin
            chk("wrap_byte255", 28'(bytes_q[255]), 28'hFF);
            chk("wrap_byte256", 28'(bytes_q[256]), 28'h00);
            chk("wrap_byte299", 28'(bytes_q[299]), 28'h2B);
            chk("wrap_line2_start", 28'(bytes_q[300]), 28'h00);
        end

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
